convn_window_sched: RTL

//   Sequences a convn multi-channel convolution datapath over one IMG_H x IMG_W feature map.

---
 rtl/convn_window_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/convn_window_sched.sv
// convn_window_sched: scans a feature map column by column into a convn
// datapath and tags each pipelined result with its output-map position.
module convn_window_sched #(
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int KERNEL_SIZE = 5,
    parameter int CONV_LAT    = 2,
    parameter int OUT_WIDTH   = 8,
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int OH  = IMG_H - KERNEL_SIZE + 1,
    localparam int OWD = IMG_W - KERNEL_SIZE + 1,
    localparam int ORW = (OH > 1) ? $clog2(OH) : 1,
    localparam int OCW = (OWD > 1) ? $clog2(OWD) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [RW-1:0]        src_row,
    output logic [CW-1:0]        src_col,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic                 conv_en,
    input  logic [OUT_WIDTH-1:0] conv_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [ORW-1:0]       out_row,
    output logic [OCW-1:0]       out_col
);

    localparam int LW = $clog2(CONV_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [RW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [LW-1:0]  r_fcnt;
    logic           r_tv   [CONV_LAT];
    logic [ORW-1:0] r_trow [CONV_LAT];
    logic [OCW-1:0] r_tcol [CONV_LAT];

    logic           w_stall;
    logic           w_beat;
    logic           w_last;
    logic           w_row_end;
    logic           w_flush_end;
    logic           w_ent_v;
    logic [CW-1:0]  w_ent_cfull;
    logic [OCW-1:0] w_ent_col;
    logic [ORW-1:0] w_ent_row;

    // A held result freezes both the source side and the convn pipeline.
    assign w_stall     = r_tv[CONV_LAT-1] & ~out_ready;
    assign w_beat      = src_valid & src_ready;
    assign w_row_end   = (r_col == CW'(IMG_W - 1));
    assign w_last      = w_row_end && (r_row == RW'(IMG_H - KERNEL_SIZE));
    assign w_flush_end = (r_fcnt == LW'(CONV_LAT - 1));

    // Columns left of the first full window only warm up the kernel.
    assign w_ent_v     = (r_state == S_FEED) &&
                         (r_col >= CW'(KERNEL_SIZE - 1));
    assign w_ent_cfull = r_col - CW'(KERNEL_SIZE - 1);
    assign w_ent_col   = OCW'(w_ent_cfull);
    assign w_ent_row   = ORW'(r_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start)                  w_next = S_FEED;
            S_FEED:  if (w_beat && w_last)       w_next = S_FLUSH;
            S_FLUSH: if (conv_en && w_flush_end) w_next = S_DRAIN;
            S_DRAIN: if (done)                   w_next = S_IDLE;
            default:                             w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        src_ready = 1'b0;
        conv_en   = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_FEED: begin
                src_ready = ~w_stall;
                conv_en   = ~w_stall & src_valid;
            end
            S_FLUSH: begin
                conv_en   = ~w_stall;
            end
            S_DRAIN: begin
                done      = ~r_tv[CONV_LAT-1] | out_ready;
            end
            default: begin
                src_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_fcnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_row  <= '0;
                r_col  <= '0;
                r_fcnt <= '0;
            end
        end else begin
            if (w_beat) begin
                if (w_row_end) begin
                    r_col <= '0;
                    if (!w_last) begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if ((r_state == S_FLUSH) && conv_en) begin
                r_fcnt <= r_fcnt + LW'(1);
            end
        end
    end

    // Tags travel in lock-step with the convn pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CONV_LAT; i++) begin
                r_tv[i]   <= 1'b0;
                r_trow[i] <= '0;
                r_tcol[i] <= '0;
            end
        end else if (conv_en) begin
            r_tv[0]   <= w_ent_v;
            r_trow[0] <= w_ent_row;
            r_tcol[0] <= w_ent_col;
            for (int i = 1; i < CONV_LAT; i++) begin
                r_tv[i]   <= r_tv[i-1];
                r_trow[i] <= r_trow[i-1];
                r_tcol[i] <= r_tcol[i-1];
            end
        end
    end

    assign src_row   = r_row;
    assign src_col   = r_col;
    assign out_valid = r_tv[CONV_LAT-1];
    assign out_data  = conv_value;
    assign out_row   = r_trow[CONV_LAT-1];
    assign out_col   = r_tcol[CONV_LAT-1];

endmodule
